// File: rtl/ct_f_spsram_arb_ctrl_if.sv
// rtl/ct_f_spsram_arb_ctrl_if.sv - requester-side bus of the single-port SRAM arbiter
//
// Purpose: bundles both requester channels and the shared read response.
// Ports (signals):
//   req0_*/req1_* : vld, wr, addr, wdata, wmask (master -> slave), rdy (slave -> master)
//   rsp0_vld/rsp1_vld, rsp_rdata : read response (slave -> master)
// Modports: master = requester side, slave = controller side.

interface ct_f_spsram_arb_ctrl_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 128
);
  logic                  req0_vld;
  logic                  req0_wr;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic [DATA_WIDTH-1:0] req0_wmask;
  logic                  req0_rdy;
  logic                  req1_vld;
  logic                  req1_wr;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic [DATA_WIDTH-1:0] req1_wmask;
  logic                  req1_rdy;
  logic                  rsp0_vld;
  logic                  rsp1_vld;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req0_vld, req0_wr, req0_addr, req0_wdata, req0_wmask,
    output req1_vld, req1_wr, req1_addr, req1_wdata, req1_wmask,
    input  req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, rsp_rdata
  );

  modport slave (
    input  req0_vld, req0_wr, req0_addr, req0_wdata, req0_wmask,
    input  req1_vld, req1_wr, req1_addr, req1_wdata, req1_wmask,
    output req0_rdy, req1_rdy, rsp0_vld, rsp1_vld, rsp_rdata
  );
endinterface

// File: rtl/ct_f_spsram_arb_ctrl.sv
// rtl/ct_f_spsram_arb_ctrl.sv - zero-fill controller and round-robin arbiter for one single-port SRAM
//
// Purpose: after reset (or init_req) writes zero to every address, then shares the
// single macro port between two requesters with a round-robin tie break.
// Ports:
//   forever_cpuclk : clock
//   cpurst_b       : synchronous active-low reset
//   init_req       : pulse that restarts the zero-fill (INIT_EN=1 only)
//   init_done      : high while in RUN
//   bus            : requester channels and read response (slave modport)
//   sram_a/cen/gwen/wen/d : macro pins, enables active-low
//   sram_q         : macro read data, valid one cycle after the read access

module ct_f_spsram_arb_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 128,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_done,
  ct_f_spsram_arb_ctrl_if.slave bus,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [0:0] ST_RST  = INIT_EN ? ST_INIT : ST_RUN;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  last_gnt;   // index of the requester granted most recently
  logic [1:0]            rd_pend;
  logic [ADDR_WIDTH-1:0] a_hold;
  logic [DATA_WIDTH-1:0] d_hold;

  logic                  in_run;
  logic                  in_init;
  logic                  gnt0;
  logic                  gnt1;
  logic                  gnt_wr;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0] gnt_wdata;
  logic [DATA_WIDTH-1:0] gnt_wmask;

  // Gating with cpurst_b keeps the macro idle and all grants/responses low
  // for the whole time reset is held, not only after the first reset edge.
  assign in_run  = cpurst_b && (state == ST_RUN);
  assign in_init = cpurst_b && (state == ST_INIT);

  // Tie goes to the requester that did not win last time.
  assign gnt0 = in_run && bus.req0_vld && (!bus.req1_vld ||  last_gnt);
  assign gnt1 = in_run && bus.req1_vld && (!bus.req0_vld || !last_gnt);

  assign bus.req0_rdy  = gnt0;
  assign bus.req1_rdy  = gnt1;
  assign bus.rsp0_vld  = cpurst_b && rd_pend[0];
  assign bus.rsp1_vld  = cpurst_b && rd_pend[1];
  assign bus.rsp_rdata = sram_q;
  assign init_done     = (state == ST_RUN);

  assign gnt_wr    = gnt1 ? bus.req1_wr    : bus.req0_wr;
  assign gnt_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
  assign gnt_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
  assign gnt_wmask = gnt1 ? bus.req1_wmask : bus.req0_wmask;

  // Address and data hold their last driven value on idle cycles.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = a_hold;
    sram_d    = d_hold;
    if (in_init) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt;
      sram_d    = '0;
    end else if (gnt0 || gnt1) begin
      sram_cen = 1'b0;
      sram_a   = gnt_addr;
      if (gnt_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~gnt_wmask;
        sram_d    = gnt_wdata;
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state    <= ST_RST;
      init_cnt <= '0;
      last_gnt <= 1'b1;
      rd_pend  <= 2'b00;
      a_hold   <= '0;
      d_hold   <= '0;
    end else begin
      a_hold  <= sram_a;
      d_hold  <= sram_d;
      rd_pend <= {gnt1 && !bus.req1_wr, gnt0 && !bus.req0_wr};
      if (gnt0) begin
        last_gnt <= 1'b0;
      end else if (gnt1) begin
        last_gnt <= 1'b1;
      end
      if (INIT_EN && init_req) begin
        state    <= ST_INIT;
        init_cnt <= '0;
      end else if (state == ST_INIT) begin
        // Counter wraps to 0 on the last address, leaving it ready for the next fill.
        init_cnt <= init_cnt + CNT_ONE;
        if (init_cnt == {ADDR_WIDTH{1'b1}}) begin
          state <= ST_RUN;
        end
      end
    end
  end

endmodule
